// File: rtl/spi_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_bridge
// Description : Single-word request port to a 23LC512-style serial SRAM,
//               one 40-bit SPI mode-0 frame per 16-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sram_bridge #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int              C_HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_HW-1:0] C_HMAX = C_HW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DESEL = 3'd4
    } state_t;

    state_t          r_state_q,  w_state_d;
    logic [C_HW-1:0] r_hcnt_q,   w_hcnt_d;
    logic [5:0]      r_bitcnt_q, w_bitcnt_d;
    logic [39:0]     r_frame_q,  w_frame_d;
    logic [15:0]     r_rx_q,     w_rx_d;
    logic            r_we_q,     w_we_d;
    logic            r_cs_n_q,   w_cs_n_d;
    logic            r_sck_q,    w_sck_d;
    logic            r_mosi_q,   w_mosi_d;
    logic            r_ready_q,  w_ready_d;
    logic [15:0]     r_rdata_q,  w_rdata_d;

    logic            w_hdone;
    logic [39:0]     w_frame_new;
    logic            w_unused_addr;

    assign w_unused_addr = mem_addr[15];
    assign w_hdone       = (r_hcnt_q == C_HMAX);

    // Word address becomes an even byte address; read frames carry zero data bits.
    assign w_frame_new = {mem_we ? 8'h02 : 8'h03, mem_addr[14:0], 1'b0,
                          mem_we ? mem_wdata : 16'h0000};

    always_comb begin
        w_state_d  = r_state_q;
        w_hcnt_d   = w_hdone ? '0 : r_hcnt_q + 1'b1;
        w_bitcnt_d = r_bitcnt_q;
        w_frame_d  = r_frame_q;
        w_rx_d     = r_rx_q;
        w_we_d     = r_we_q;
        w_cs_n_d   = r_cs_n_q;
        w_sck_d    = r_sck_q;
        w_mosi_d   = r_mosi_q;
        w_ready_d  = r_ready_q;
        w_rdata_d  = r_rdata_q;

        case (r_state_q)
            S_IDLE: begin
                w_hcnt_d = '0;
                if (mem_req && r_ready_q) begin
                    w_state_d  = S_SETUP;
                    w_ready_d  = 1'b0;
                    w_cs_n_d   = 1'b0;
                    w_sck_d    = 1'b0;
                    w_we_d     = mem_we;
                    w_frame_d  = w_frame_new;
                    w_mosi_d   = w_frame_new[39];
                    w_bitcnt_d = 6'd39;
                end
            end
            S_SETUP: begin
                if (w_hdone) begin
                    w_state_d = S_SHIFT;
                    w_sck_d   = 1'b1;
                    w_rx_d    = {r_rx_q[14:0], spi_miso};
                end
            end
            S_SHIFT: begin
                if (w_hdone) begin
                    if (r_sck_q) begin
                        w_sck_d = 1'b0;
                        if (r_bitcnt_q == 6'd0) begin
                            w_state_d = S_HOLD;
                            w_mosi_d  = 1'b0;
                        end else begin
                            w_frame_d  = {r_frame_q[38:0], 1'b0};
                            w_mosi_d   = r_frame_q[38];
                            w_bitcnt_d = r_bitcnt_q - 1'b1;
                        end
                    end else begin
                        // MISO is sampled on the same edge that raises SCK.
                        w_sck_d = 1'b1;
                        w_rx_d  = {r_rx_q[14:0], spi_miso};
                    end
                end
            end
            S_HOLD: begin
                if (w_hdone) begin
                    w_state_d = S_DESEL;
                    w_cs_n_d  = 1'b1;
                    if (!r_we_q) begin
                        w_rdata_d = r_rx_q;
                    end
                end
            end
            S_DESEL: begin
                if (w_hdone) begin
                    w_state_d = S_IDLE;
                    w_ready_d = 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_hcnt_q   <= '0;
            r_bitcnt_q <= '0;
            r_frame_q  <= '0;
            r_rx_q     <= '0;
            r_we_q     <= 1'b0;
            r_cs_n_q   <= 1'b1;
            r_sck_q    <= 1'b0;
            r_mosi_q   <= 1'b0;
            r_ready_q  <= 1'b1;
            r_rdata_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_hcnt_q   <= w_hcnt_d;
            r_bitcnt_q <= w_bitcnt_d;
            r_frame_q  <= w_frame_d;
            r_rx_q     <= w_rx_d;
            r_we_q     <= w_we_d;
            r_cs_n_q   <= w_cs_n_d;
            r_sck_q    <= w_sck_d;
            r_mosi_q   <= w_mosi_d;
            r_ready_q  <= w_ready_d;
            r_rdata_q  <= w_rdata_d;
        end
    end

    assign mem_rdata = r_rdata_q;
    assign mem_ready = r_ready_q;
    assign spi_cs_n  = r_cs_n_q;
    assign spi_sck   = r_sck_q;
    assign spi_mosi  = r_mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_sram_bridge
// Description : Scoreboarded bench for spi_sram_bridge at CLK_DIV=2 and 1,
//               each instance talking to a behavioural serial SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sram_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic [15:0] rdata [2];
    logic        ready [2];
    logic        cs_n  [2];
    logic        sck   [2];
    logic        mosi  [2];

    typedef struct packed {
        logic [39:0] frame;
        logic [15:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_rd [2];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int H = (g == 0) ? 2 : 1;

        logic        miso_l;
        logic [7:0]  mem [0:65535];
        logic [39:0] cap;
        logic [15:0] rd_sr;
        logic [15:0] a1;
        int          rises;
        int          frames;
        int          run_r;
        int          run_s;
        logic        p_cs;
        logic        p_sck;
        logic        p_mosi;
        exp_t        e;

        spi_sram_bridge #(.CLK_DIV(H)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mem_req   (req[g]),
            .mem_we    (we[g]),
            .mem_addr  (addr[g]),
            .mem_wdata (wdata[g]),
            .mem_rdata (rdata[g]),
            .mem_ready (ready[g]),
            .spi_cs_n  (cs_n[g]),
            .spi_sck   (sck[g]),
            .spi_mosi  (mosi[g]),
            .spi_miso  (miso_l)
        );

        initial begin
            for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
            mem[16'h2468] = 8'hA5;
            mem[16'h2469] = 8'hC3;
            mem[16'h0000] = 8'h3C;
            mem[16'h0001] = 8'h7E;
            mem[16'hFFFE] = 8'h5A;
            mem[16'hFFFF] = 8'h96;
            miso_l = 1'b0;
            cap = '0; rd_sr = '0; a1 = '0;
            rises = 0; frames = 0; run_r = 0; run_s = 0;
            p_cs = 1'b1; p_sck = 1'b0; p_mosi = 1'b0;
        end

        // Serial SRAM: sequential mode, data out on SCK falling edges.
        always @(negedge cs_n[g]) begin
            cap = '0;
            rises = 0;
            frames++;
        end

        always @(posedge sck[g]) begin
            if (cs_n[g] == 1'b0) begin
                cap = {cap[38:0], mosi[g]};
                rises++;
                if (rises == 24 && cap[23:16] == 8'h03) begin
                    a1 = cap[15:0] + 16'd1;
                    rd_sr = {mem[cap[15:0]], mem[a1]};
                end
                if (rises == 32 && cap[31:24] == 8'h02) mem[cap[23:8]] = cap[7:0];
                if (rises == 40 && cap[39:32] == 8'h02) begin
                    a1 = cap[31:16] + 16'd1;
                    mem[a1] = cap[7:0];
                end
            end
        end

        always @(negedge sck[g]) begin
            if (cs_n[g] == 1'b0 && rises >= 24) begin
                miso_l = rd_sr[15];
                rd_sr  = {rd_sr[14:0], 1'b0};
            end
        end

        // Output monitor: busy length, SCK phase widths, MOSI timing, and
        // scoreboard pop when chip select releases at the end of a frame.
        always @(posedge clk) begin
            #1;
            if (rst) begin
                run_r = 0;
                run_s = 0;
            end else begin
                if (!ready[g]) run_r++;
                else if (run_r != 0) begin
                    check_eq($sformatf("ready_low_h%0d", H), 64'(run_r), 64'(82 * H));
                    run_r = 0;
                end
                if (!cs_n[g] && !p_cs) begin
                    if (sck[g] == p_sck) run_s++;
                    else begin
                        check_eq(p_sck ? "sck_high" : "sck_low", 64'(run_s), 64'(H));
                        run_s = 1;
                    end
                    if (mosi[g] != p_mosi)
                        check_eq("mosi_on_fall", {63'd0, p_sck & ~sck[g]}, 64'd1);
                end else begin
                    run_s = 1;
                end
                if (cs_n[g] && !p_cs) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_unexpected_frame", 64'(frames), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("frame", 64'(cap), 64'(e.frame));
                        check_eq("sck_rises", 64'(rises), 64'd40);
                        check_eq("rdata", 64'(rdata[g]), 64'(e.rd));
                    end
                end
            end
            p_cs   = cs_n[g];
            p_sck  = sck[g];
            p_mosi = mosi[g];
        end
    end

    task automatic push_exp(input int g, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] rd_exp);
        exp_t x;
        if (!w) exp_rd[g] = rd_exp;
        x.frame = {w ? 8'h02 : 8'h03, a[14:0], 1'b0, w ? d : 16'h0000};
        x.rd    = exp_rd[g];
        sb.push_back(x);
    endtask

    task automatic issue(input int g, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] rd_exp, input bit keep);
        int t = 0;
        while (ready[g] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check_eq("issue_timeout", 64'(t), 64'd0);
        req[g] = 1'b1; we[g] = w; addr[g] = a; wdata[g] = d;
        push_exp(g, w, a, d, rd_exp);
        @(posedge clk);
        #1;
        check_eq("accepted", {63'd0, ready[g]}, 64'd0);
        if (!keep) req[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while (ready[g] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check_eq("idle_timeout", 64'(t), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        int f0;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; exp_rd[i] = '0;
        end
        req[0] = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_cs_n",  {63'd0, cs_n[0]},  64'd1);
        check_eq("rst_sck",   {63'd0, sck[0]},   64'd0);
        check_eq("rst_mosi",  {63'd0, mosi[0]},  64'd0);
        check_eq("rst_ready", {63'd0, ready[0]}, 64'd1);
        check_eq("rst_rdata", 64'(rdata[0]),     64'd0);
        req[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Read 0x1234 -> byte address 0x2468
        issue(0, 1'b0, 16'h1234, 16'h0000, 16'hA5C3, 1'b0);
        wait_idle(0);

        // Write with bit 15 set; rdata keeps the previous read value
        issue(0, 1'b1, 16'h8001, 16'hBEEF, 16'h0000, 1'b0);
        wait_idle(0);
        check_eq("sram_byte2", 64'(g_dut[0].mem[2]), 64'hBE);
        check_eq("sram_byte3", 64'(g_dut[0].mem[3]), 64'hEF);

        // Read back while hammering req with a conflicting write request
        f0 = g_dut[0].frames;
        issue(0, 1'b0, 16'h0001, 16'h0000, 16'hBEEF, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            req[0] = ~req[0]; we[0] = 1'b1; addr[0] = 16'h0777; wdata[0] = 16'hFFFF;
        end
        req[0] = 1'b0;
        wait_idle(0);
        repeat (10) @(negedge clk);
        check_eq("busy_one_frame", 64'(g_dut[0].frames - f0), 64'd1);

        // Back-to-back: write then read with req held high
        issue(0, 1'b1, 16'd5, 16'h1357, 16'h0000, 1'b1);
        we[0] = 1'b0; addr[0] = 16'd5;
        push_exp(0, 1'b0, 16'd5, 16'h0000, 16'h1357);
        t = 0;
        while (cs_n[0] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (cs_n[0] === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req[0] = 1'b0;
        // DESEL holds CS high for H cycles, plus the one IDLE cycle on whose
        // closing edge the held request is accepted.
        check_eq("cs_gap", 64'(n), 64'd3);
        wait_idle(0);

        // Reset in the middle of the shift phase
        issue(0, 1'b0, 16'h1234, 16'h0000, 16'hA5C3, 1'b0);
        t = 0;
        while (g_dut[0].rises != 20 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_eq("reach_20_rises", 64'(g_dut[0].rises), 64'd20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_cs_n",  {63'd0, cs_n[0]},  64'd1);
        check_eq("mid_rst_sck",   {63'd0, sck[0]},   64'd0);
        check_eq("mid_rst_mosi",  {63'd0, mosi[0]},  64'd0);
        check_eq("mid_rst_ready", {63'd0, ready[0]}, 64'd1);
        check_eq("mid_rst_rdata", 64'(rdata[0]),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        exp_rd[0] = 16'h0000;
        @(negedge clk);
        issue(0, 1'b0, 16'h0000, 16'h0000, 16'h3C7E, 1'b0);
        wait_idle(0);

        // CLK_DIV=1 instance: top word address
        issue(1, 1'b0, 16'h7FFF, 16'h0000, 16'h5A96, 1'b0);
        wait_idle(1);

        repeat (5) @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
